// File: rtl/sparam_pkg.sv
// Shared types and helpers for the two-port S-parameter sweep sequencer.
package sparam_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StAcq,
    StEmit
  } state_e;

  // Result field indices: incident, reflected and through waves.
  localparam int FldA   = 0;
  localparam int FldR   = 1;
  localparam int FldT   = 2;
  localparam int NumFld = 3;

  // Width that holds the sum of navg signed samples of width dw without wrap.
  function automatic int unsigned acc_width(int unsigned dw, int unsigned navg);
    return dw + $clog2(navg);
  endfunction

endpackage

// File: rtl/sparam_sweep_ctrl_if.sv
// Sample input and result output handshakes of the sweep sequencer.
interface sparam_sweep_ctrl_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 19,
  parameter int unsigned FW = 6
);
  logic                 smp_valid;
  logic                 smp_ready;
  logic signed [DW-1:0] smp_a_i, smp_a_q, smp_r_i, smp_r_q, smp_t_i, smp_t_q;

  logic                 res_valid;
  logic                 res_ready;
  logic        [FW-1:0] res_freq;
  logic                 res_port;
  logic signed [AW-1:0] res_a_i, res_a_q, res_r_i, res_r_q, res_t_i, res_t_q;

  // master: the sequencer (consumes samples, produces results)
  modport master (
    input  smp_valid, smp_a_i, smp_a_q, smp_r_i, smp_r_q, smp_t_i, smp_t_q,
    output smp_ready,
    output res_valid, res_freq, res_port, res_a_i, res_a_q, res_r_i, res_r_q, res_t_i, res_t_q,
    input  res_ready
  );

  // slave: the receiver front end and post-processing stage
  modport slave (
    output smp_valid, smp_a_i, smp_a_q, smp_r_i, smp_r_q, smp_t_i, smp_t_q,
    input  smp_ready,
    input  res_valid, res_freq, res_port, res_a_i, res_a_q, res_r_i, res_r_q, res_t_i, res_t_q,
    output res_ready
  );
endinterface

// File: rtl/sparam_acc.sv
// Signed I/Q accumulator pair. sum_* is the running total including the
// sample currently presented, so the caller can capture the final sum on the
// same edge that takes in the last sample.
module sparam_acc #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 19
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  output logic signed [AW-1:0] sum_re,
  output logic signed [AW-1:0] sum_im
);
  logic signed [AW-1:0] acc_re_q, acc_im_q;

  // Size casts of signed operands sign-extend.
  assign sum_re = acc_re_q + AW'(in_re);
  assign sum_im = acc_im_q + AW'(in_im);

  // Accumulate on enable; clear wins over enable.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      acc_re_q <= '0;
      acc_im_q <= '0;
    end else if (en) begin
      acc_re_q <= sum_re;
      acc_im_q <= sum_im;
    end
  end
endmodule

// File: rtl/sparam_sweep_ctrl.sv
// Sweep sequencer: steps frequency and excited port, waits for settling,
// sums NAVG samples of the a/r/t waves and emits one result per port/point.
module sparam_sweep_ctrl
  import sparam_pkg::*;
#(
  parameter int unsigned NPTS   = 64,
  parameter int unsigned SETTLE = 16,
  parameter int unsigned NAVG   = 8,
  parameter int unsigned DW     = 16,
  parameter int unsigned FW     = (NPTS > 1) ? $clog2(NPTS) : 1,
  parameter int unsigned AW     = acc_width(DW, NAVG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          src_en,
  output logic          port_sel,
  output logic [FW-1:0] freq_idx,
  sparam_sweep_ctrl_if.master bus
);
  localparam int unsigned SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned NCW = (NAVG > 1) ? $clog2(NAVG) : 1;
  localparam logic [SCW-1:0] SettleLast = SCW'(SETTLE - 1);
  localparam logic [NCW-1:0] NavgLast   = NCW'(NAVG - 1);
  localparam logic [FW-1:0]  FreqLast   = FW'(NPTS - 1);

  state_e               state_q, state_d;
  logic [SCW-1:0]       settle_cnt_q, settle_cnt_d;
  logic [NCW-1:0]       smp_cnt_q, smp_cnt_d;
  logic [FW-1:0]        freq_q, freq_d;
  logic                 port_q, port_d;
  logic                 busy_q, res_valid_q, done_q, done_d;
  logic                 xfer, last_xfer, res_load;
  logic [FW-1:0]        res_freq_q;
  logic                 res_port_q;

  logic signed [DW-1:0] smp_re [NumFld];
  logic signed [DW-1:0] smp_im [NumFld];
  logic signed [AW-1:0] sum_re [NumFld];
  logic signed [AW-1:0] sum_im [NumFld];
  logic signed [AW-1:0] res_re_q [NumFld];
  logic signed [AW-1:0] res_im_q [NumFld];

  assign smp_re[FldA] = bus.smp_a_i;
  assign smp_im[FldA] = bus.smp_a_q;
  assign smp_re[FldR] = bus.smp_r_i;
  assign smp_im[FldR] = bus.smp_r_q;
  assign smp_re[FldT] = bus.smp_t_i;
  assign smp_im[FldT] = bus.smp_t_q;

  // A transfer presented in the abort cycle is discarded.
  assign xfer      = (state_q == StAcq) && bus.smp_valid && !abort;
  assign last_xfer = xfer && (smp_cnt_q == NavgLast);

  for (genvar g = 0; g < NumFld; g++) begin : g_acc
    sparam_acc #(
      .DW(DW),
      .AW(AW)
    ) u_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_q == StSettle),
      .en    (xfer),
      .in_re (smp_re[g]),
      .in_im (smp_im[g]),
      .sum_re(sum_re[g]),
      .sum_im(sum_im[g])
    );
  end

  // Next state, index/port stepping and settle/sample counters.
  always_comb begin
    state_d  = state_q;
    freq_d   = freq_q;
    port_d   = port_q;
    done_d   = 1'b0;
    res_load = 1'b0;
    if (abort) begin
      if (state_q != StIdle) state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StSettle;
            freq_d  = '0;
            port_d  = 1'b0;
          end
        end
        StSettle: begin
          if (settle_cnt_q == SettleLast) state_d = StAcq;
        end
        StAcq: begin
          if (last_xfer) begin
            state_d  = StEmit;
            res_load = 1'b1;
          end
        end
        StEmit: begin
          if (bus.res_ready) begin
            if (!port_q) begin
              port_d  = 1'b1;
              state_d = StSettle;
            end else if (freq_q != FreqLast) begin
              freq_d  = freq_q + FW'(1);
              port_d  = 1'b0;
              state_d = StSettle;
            end else begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end
        end
      endcase
    end
    settle_cnt_d = (state_q == StSettle && state_d == StSettle) ? settle_cnt_q + SCW'(1) : '0;
    smp_cnt_d    = (state_d == StAcq) ? smp_cnt_q + NCW'(xfer) : '0;
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      settle_cnt_q <= '0;
      smp_cnt_q    <= '0;
      freq_q       <= '0;
      port_q       <= 1'b0;
      busy_q       <= 1'b0;
      res_valid_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      smp_cnt_q    <= smp_cnt_d;
      freq_q       <= freq_d;
      port_q       <= port_d;
      busy_q       <= (state_d != StIdle);
      res_valid_q  <= (state_d == StEmit);
      done_q       <= done_d;
    end
  end

  // Result registers load only on the final transfer of a measurement.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_freq_q <= '0;
      res_port_q <= 1'b0;
      for (int f = 0; f < NumFld; f++) begin
        res_re_q[f] <= '0;
        res_im_q[f] <= '0;
      end
    end else if (res_load) begin
      res_freq_q <= freq_q;
      res_port_q <= port_q;
      for (int f = 0; f < NumFld; f++) begin
        res_re_q[f] <= sum_re[f];
        res_im_q[f] <= sum_im[f];
      end
    end
  end

  assign busy      = busy_q;
  assign src_en    = busy_q;  // source is on in every non-idle state
  assign done      = done_q;
  assign port_sel  = port_q;
  assign freq_idx  = freq_q;

  assign bus.smp_ready = (state_q == StAcq);
  assign bus.res_valid = res_valid_q;
  assign bus.res_freq  = res_freq_q;
  assign bus.res_port  = res_port_q;
  assign bus.res_a_i   = res_re_q[FldA];
  assign bus.res_a_q   = res_im_q[FldA];
  assign bus.res_r_i   = res_re_q[FldR];
  assign bus.res_r_q   = res_im_q[FldR];
  assign bus.res_t_i   = res_re_q[FldT];
  assign bus.res_t_q   = res_im_q[FldT];
endmodule

// File: doc/sparam_sweep_ctrl.md
# sparam_sweep_ctrl

Digital sequencer for the two-port S-parameter measurement chain. It steps a frequency index over NPTS points and excites port 1, then port 2, at each point. After a settle interval it accepts NAVG complex samples of the incident wave (a), the reflected wave (r) and the through wave (t) over a valid/ready handshake, and sums them. It then emits one accumulated result per port per frequency to the post-processing (dB/ratio) stage. It is the receiving/measurement end of the stimulus network: the balun/filter DUT sits between its source controls and its sample input.

## Interface
- NPTS, 64: frequency points per sweep (≥1)
- SETTLE, 16: settle cycles after each excitation change (≥1)
- NAVG, 8: samples summed per measurement; power of two, ≥1
- DW, 16: signed sample width
- FW, $clog2(NPTS) (min 1): frequency index width
- AW, DW+$clog2(NAVG): signed accumulator width

Ports:
- clk  in  1  clock; all logic rising-edge
- rst_n  in  1  synchronous reset, active low
- start  in  1  begin sweep; sampled only in IDLE
- abort  in  1  terminate sweep; highest priority after reset
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last result handshake
- src_en  out  1  source enable; high in SETTLE/ACQ/EMIT
- port_sel  out  1  0 = port 1 excited, 1 = port 2
- freq_idx  out  FW  current frequency index
- smp_valid  in  1  sample present
- smp_ready  out  1  high only in ACQ
- smp_a_i, smp_a_q, smp_r_i, smp_r_q, smp_t_i, smp_t_q  in  DW each  signed sample fields
- res_valid  out  1  result present (EMIT)
- res_ready  in  1  downstream accepts
- res_freq  out  FW; res_port  out  1
- res_a_i, res_a_q, res_r_i, res_r_q, res_t_i, res_t_q  out  AW each  signed sums

## Operation
- States: IDLE, SETTLE, ACQ, EMIT.
- IDLE: start=1 → SETTLE, freq_idx=0, port_sel=0.
- SETTLE: clear all accumulators and the sample count on entry. Count SETTLE cycles, then → ACQ.
- ACQ: smp_ready=1. Each cycle with smp_valid=1 is one transfer: add each field, sign-extended to AW, to its accumulator. After the NAVG-th transfer → EMIT. Cycles without smp_valid are gaps and add nothing.
- EMIT: res_valid=1. Result fields are the final sums, res_freq=freq_idx, res_port=port_sel. They hold stable until res_ready=1. On handshake:
  - port_sel=0 → port_sel=1, same freq, go to SETTLE.
  - port_sel=1 and freq_idx<NPTS-1 → freq_idx+1, port_sel=0, go to SETTLE.
  - port_sel=1 and freq_idx=NPTS-1 → IDLE, done=1 for one cycle.
- Boundary rules:
  - start while busy: ignored.
  - smp_valid outside ACQ: dropped; smp_ready is low.
  - Sums cannot overflow at AW.
- abort (any state except IDLE) → IDLE next edge. src_en, res_valid and smp_ready go low; no result and no done. A transfer presented in the abort cycle is not counted.
- Reset values: state IDLE, busy 0, done 0, src_en 0, port_sel 0, freq_idx 0, smp_ready 0, res_valid 0, all res_* fields 0.

## Timing
- All outputs are registered from state except smp_ready, which is decoded from state with no input dependence.
- Entering SETTLE at edge t gives first ACQ cycle at t+SETTLE.
- Latency per measurement with no gaps and res_ready=1: SETTLE + NAVG + 1 cycles. A full sweep takes 2·NPTS times that; done asserts the cycle after the final handshake.
- port_sel, freq_idx and src_en change only on the edge that enters SETTLE or IDLE. They are constant during ACQ.
- res_* update only on the ACQ→EMIT edge.

## Structure
- Package sparam_pkg: state enum, result field-index constants, AW width function.
- Sub-module sparam_acc: one signed I/Q accumulator pair with clear, enable and sign extension. Instantiate three times (a, r, t).
- Top holds the FSM, the settle/sample counters, the index/port registers and the result registers.

## Test plan
- NPTS=2, SETTLE=3, NAVG=4, constant samples a=(100,-50), r=(10,0), t=(-7,3), smp_valid=1, res_ready=1 → 4 results in order (f0,p0),(f0,p1),(f1,p0),(f1,p1). Each has a=(400,-200), r=(40,0), t=(-28,12); period 8 cycles; done one cycle after the 4th.
- Same setup with res_ready held low 5 cycles in the first EMIT → res_* stable for 5 cycles, src_en stays high, smp_ready low, no extra transfers.
- smp_valid toggling 1,0,1,0… → 4 transfers over 7 ACQ cycles, sums unchanged from the first case.
- Samples -32768 on every field, NAVG=8 → sums -262144 at AW=19, no wrap.
- abort in the second ACQ cycle → IDLE next edge, busy=0, src_en=0, no res_valid, no done. A following start restarts at f0,p0.
- start pulsed during SETTLE and EMIT → no effect. smp_valid during SETTLE → not counted (sums as in the first case).
